// File: rtl/receptor_pkg.sv
// Shared types and default sizing for the serial receptor controller.
package receptor_pkg;

  localparam int unsigned SIZESREG_DEF     = 16;
  localparam int unsigned CLKS_PER_BIT_DEF = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } rx_state_e;

endpackage

// File: rtl/receptor.sv
// Serial-in parallel-out receptor: shifts signal_in into the LSB on each enable strobe (MSB-first frames).
module receptor
  import receptor_pkg::*;
#(
  parameter int unsigned SIZESREG = SIZESREG_DEF
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                enable,
  input  logic                signal_in,
  output logic [SIZESREG-1:0] output_reg
);

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      output_reg <= '0;
    end else if (enable) begin
      output_reg <= {output_reg[SIZESREG-2:0], signal_in};
    end
  end

endmodule

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit, with a configurable reset level.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/receptor_ctrl.sv
// Asynchronous serial frame receiver: drives an external shift-register receptor bit by bit
// and presents each good frame through a one-deep valid/ready output slot.
module receptor_ctrl
  import receptor_pkg::*;
#(
  parameter int unsigned SIZESREG     = SIZESREG_DEF,
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                line_in,
  output logic                sr_enable,
  output logic                sr_data,
  input  logic [SIZESREG-1:0] sr_q,
  output logic [SIZESREG-1:0] frame_data,
  output logic                frame_valid,
  input  logic                frame_ready,
  output logic                frame_err,
  output logic                overrun
);

  localparam int unsigned TW = $clog2(CLKS_PER_BIT);
  localparam int unsigned BW = $clog2(SIZESREG);
  localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] T_HALF = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] B_LAST = BW'(SIZESREG - 1);

  logic            line_s;
  rx_state_e       state;
  logic [TW-1:0]   timer;
  logic [BW-1:0]   bit_cnt;

  sync_2ff #(.RESET_VAL(1'b1)) u_sync (
    .clk   (CLK),
    .rst_n (RST_N),
    .d     (line_in),
    .q     (line_s)
  );

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state       <= S_IDLE;
      timer       <= '0;
      bit_cnt     <= '0;
      sr_enable   <= 1'b0;
      sr_data     <= 1'b0;
      frame_data  <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      sr_enable <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      if (frame_valid && frame_ready) begin
        frame_valid <= 1'b0;
      end
      case (state)
        S_IDLE: begin
          if (!line_s) begin
            state <= S_START;
            timer <= '0;
          end
        end
        S_START: begin
          if (timer == T_HALF) begin
            timer <= '0;
            state <= line_s ? S_IDLE : S_DATA;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_DATA: begin
          if (timer == T_LAST) begin
            timer     <= '0;
            sr_enable <= 1'b1;
            sr_data   <= line_s;
            if (bit_cnt == B_LAST) begin
              bit_cnt <= '0;
              state   <= S_STOP;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_STOP: begin
          if (timer == T_LAST) begin
            timer <= '0;
            if (line_s) begin
              state <= S_IDLE;
              // A ready consumer frees the slot on this same edge, so the new frame can replace it.
              if (!frame_valid || frame_ready) begin
                frame_data  <= sr_q;
                frame_valid <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
            end else begin
              frame_err <= 1'b1;
              state     <= S_BREAK;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_BREAK: begin
          if (line_s) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_receptor_ctrl.sv
// Bench for receptor_ctrl + receptor: directed frame scenarios plus randomized frames
// checked against a one-slot transaction model of the output handshake.
module tb_receptor_ctrl;
  import receptor_pkg::*;

  localparam int unsigned W   = 16;
  localparam int unsigned CPB = 4;

  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic          line_in = 1'b1;
  logic          frame_ready = 1'b0;
  logic          sr_enable, sr_data;
  logic [W-1:0]  sr_q, frame_data;
  logic          frame_valid, frame_err, overrun;

  always #5 CLK = ~CLK;

  receptor_ctrl #(.SIZESREG(W), .CLKS_PER_BIT(CPB)) dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .line_in     (line_in),
    .sr_enable   (sr_enable),
    .sr_data     (sr_data),
    .sr_q        (sr_q),
    .frame_data  (frame_data),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .frame_err   (frame_err),
    .overrun     (overrun)
  );

  receptor #(.SIZESREG(W)) u_rx (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .enable     (sr_enable),
    .signal_in  (sr_data),
    .output_reg (sr_q)
  );

  // Monitor: observes the DUT on the falling edge and only records what it sees.
  int           cyc = 0, last_strobe = -1000;
  int           n_strobe = 0, n_err = 0, n_ovr = 0, n_valid_cyc = 0;
  int           n_gap_bad = 0, n_unstable = 0;
  logic         prev_valid = 1'b0, prev_acc = 1'b0;
  logic [W-1:0] prev_data = '0;
  logic [W-1:0] got_q[$];

  always @(negedge CLK) begin
    cyc <= cyc + 1;
    if (sr_enable) begin
      n_strobe <= n_strobe + 1;
      if ((cyc - last_strobe) <= 2 * int'(CPB) && (cyc - last_strobe) != int'(CPB))
        n_gap_bad <= n_gap_bad + 1;
      last_strobe <= cyc;
    end
    if (frame_err)   n_err <= n_err + 1;
    if (overrun)     n_ovr <= n_ovr + 1;
    if (frame_valid) n_valid_cyc <= n_valid_cyc + 1;
    if (frame_valid && prev_valid && !prev_acc && frame_data != prev_data)
      n_unstable <= n_unstable + 1;
    if (frame_valid && frame_ready) got_q.push_back(frame_data);
    prev_valid <= frame_valid;
    prev_acc   <= frame_valid && frame_ready;
    prev_data  <= frame_data;
  end

  int errors = 0, checks = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int unsigned n);
    line_in = 1'b1;
    repeat (n) tick();
  endtask

  // Start bit, W data bits MSB first, then the stop bit; leaves line_in at the stop level.
  task automatic send_frame(input logic [W-1:0] d, input logic stop);
    line_in = 1'b0;
    repeat (CPB) tick();
    for (int i = int'(W) - 1; i >= 0; i--) begin
      line_in = d[i];
      repeat (CPB) tick();
    end
    line_in = stop;
    repeat (CPB) tick();
  endtask

  // Reference model: expected accepted frames and the single output slot.
  logic [W-1:0] exp_q[$];
  int           got_rd = 0, exp_rd = 0;
  logic         slot_full = 1'b0;
  logic [W-1:0] slot_val = '0;

  task automatic compare_acc(input string tag);
    check_eq({tag, "_acc_cnt"}, got_q.size() - got_rd, exp_q.size() - exp_rd);
    while (got_rd < got_q.size() && exp_rd < exp_q.size()) begin
      check_eq({tag, "_acc_data"}, got_q[got_rd], exp_q[exp_rd]);
      got_rd++;
      exp_rd++;
    end
    got_rd = got_q.size();
    exp_rd = exp_q.size();
  endtask

  int           s0, v0, e0, o0, exp_err, exp_ovr, waited, hold;
  logic [W-1:0] d;
  logic         good, r;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1);
  end

  initial begin
    repeat (3) tick();
    check_eq("rst_sr_enable", sr_enable, 0);
    check_eq("rst_sr_data", sr_data, 0);
    check_eq("rst_frame_data", frame_data, 0);
    check_eq("rst_frame_valid", frame_valid, 0);
    check_eq("rst_frame_err", frame_err, 0);
    check_eq("rst_overrun", overrun, 0);
    RST_N = 1'b1;
    idle(10);

    // Single good frame with a ready consumer.
    s0 = n_strobe; v0 = n_valid_cyc;
    frame_ready = 1'b1;
    send_frame(16'hA5C3, 1'b1);
    idle(2 * CPB);
    exp_q.push_back(16'hA5C3);
    check_eq("a5c3_strobes", n_strobe - s0, W);
    check_eq("a5c3_valid_cycles", n_valid_cyc - v0, 1);
    check_eq("a5c3_valid_after", frame_valid, 0);
    compare_acc("a5c3");

    // One-cycle low glitch on an idle line.
    s0 = n_strobe; v0 = n_valid_cyc;
    line_in = 1'b0;
    tick();
    idle(20);
    check_eq("glitch_strobes", n_strobe - s0, 0);
    check_eq("glitch_valid_cycles", n_valid_cyc - v0, 0);

    // Bad stop bit followed by a held-low line, then recovery.
    e0 = n_err; v0 = n_valid_cyc;
    send_frame(16'h1234, 1'b0);
    line_in = 1'b0;
    repeat (20) tick();
    idle(4 * CPB);
    check_eq("bad_stop_err", n_err - e0, 1);
    check_eq("bad_stop_valid_cycles", n_valid_cyc - v0, 0);
    check_eq("bad_stop_valid", frame_valid, 0);
    send_frame(16'h00FF, 1'b1);
    idle(2 * CPB);
    exp_q.push_back(16'h00FF);
    check_eq("recover_err", n_err - e0, 1);
    compare_acc("recover");

    // Two frames with no consumer: second one overruns.
    frame_ready = 1'b0;
    o0 = n_ovr;
    send_frame(16'h1111, 1'b1);
    idle(2 * CPB);
    send_frame(16'h2222, 1'b1);
    idle(2 * CPB);
    check_eq("ovr_pulse", n_ovr - o0, 1);
    check_eq("ovr_data_kept", frame_data, 16'h1111);
    check_eq("ovr_valid", frame_valid, 1);
    frame_ready = 1'b1;
    exp_q.push_back(16'h1111);
    tick();
    frame_ready = 1'b0;
    tick();
    check_eq("ovr_valid_cleared", frame_valid, 0);
    compare_acc("ovr");

    // Consumer accepts the pending frame on exactly the cycle the next frame loads.
    o0 = n_ovr;
    send_frame(16'h2222, 1'b1);
    idle(2 * CPB);
    check_eq("coll_pending_data", frame_data, 16'h2222);
    fork
      send_frame(16'h3333, 1'b1);
      begin
        repeat (CPB * (W + 2)) tick();
        frame_ready = 1'b1;
        tick();
        frame_ready = 1'b0;
      end
    join
    idle(2 * CPB);
    exp_q.push_back(16'h2222);
    check_eq("coll_no_overrun", n_ovr - o0, 0);
    check_eq("coll_valid", frame_valid, 1);
    check_eq("coll_data", frame_data, 16'h3333);
    compare_acc("coll");
    slot_full = 1'b1;
    slot_val  = 16'h3333;

    // Randomized frames against the one-slot model.
    e0 = n_err; o0 = n_ovr; exp_err = 0; exp_ovr = 0;
    for (int k = 0; k < 12; k++) begin
      d    = W'($urandom);
      good = ($urandom_range(0, 3) != 0);
      r    = 1'($urandom_range(0, 1));
      frame_ready = r;
      if (r && slot_full) begin
        exp_q.push_back(slot_val);
        slot_full = 1'b0;
      end
      idle(CPB);
      send_frame(d, good);
      if (!good) begin
        exp_err++;
        hold = int'($urandom_range(0, 10));
        line_in = 1'b0;
        repeat (hold) tick();
      end else if (!slot_full) begin
        slot_val  = d;
        slot_full = 1'b1;
        if (r) begin
          exp_q.push_back(d);
          slot_full = 1'b0;
        end
      end else begin
        exp_ovr++;
      end
      idle(2 * CPB);
      check_eq("rnd_err", n_err - e0, exp_err);
      check_eq("rnd_ovr", n_ovr - o0, exp_ovr);
      check_eq("rnd_valid", frame_valid, slot_full);
      if (slot_full) check_eq("rnd_data", frame_data, slot_val);
      compare_acc("rnd");
    end

    // Reset pulse in the middle of a frame.
    frame_ready = 1'b0;
    s0 = n_strobe; e0 = n_err;
    fork
      send_frame(16'hFFFF, 1'b1);
      begin
        waited = 0;
        while ((n_strobe - s0) < 8 && waited < 200) begin
          tick();
          waited++;
        end
        check_eq("midrst_reached_8", (n_strobe - s0) >= 8, 1);
        RST_N = 1'b0;
        tick();
        RST_N = 1'b1;
        check_eq("midrst_sr_enable", sr_enable, 0);
        check_eq("midrst_sr_data", sr_data, 0);
        check_eq("midrst_frame_data", frame_data, 0);
        check_eq("midrst_frame_valid", frame_valid, 0);
        check_eq("midrst_frame_err", frame_err, 0);
        check_eq("midrst_overrun", overrun, 0);
      end
    join
    slot_full = 1'b0;
    idle(3 * CPB);
    check_eq("midrst_strobes", n_strobe - s0, 8);
    check_eq("midrst_no_err", n_err - e0, 0);
    check_eq("midrst_valid_after", frame_valid, 0);
    frame_ready = 1'b1;
    send_frame(16'h0F0F, 1'b1);
    idle(2 * CPB);
    exp_q.push_back(16'h0F0F);
    compare_acc("after_rst");

    check_eq("strobe_spacing_violations", n_gap_bad, 0);
    check_eq("frame_data_unstable", n_unstable, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/receptor_ctrl.md
RECEPTOR_CTRL -- requirements
Module: receptor_ctrl

Interface
REQ-001 Parameter SIZESREG, 16, number of data bits per frame; equals the width of the receptor shift register.
REQ-002 Parameter CLKS_PER_BIT, 4, CLK cycles per serial bit; even, >=4.
REQ-003 CLK  input  1  single clock, rising edge.
REQ-004 RST_N  input  1  reset, synchronous and active-low.
REQ-005 line_in  input  1  asynchronous serial line, idle high.
REQ-006 sr_enable  output  1  one-cycle shift strobe to receptor enable.
REQ-007 sr_data  output  1  sampled bit to receptor signal_in, valid while sr_enable=1.
REQ-008 sr_q  input  SIZESREG  parallel content of receptor output_reg.
REQ-009 frame_data  output  SIZESREG  captured frame.
REQ-010 frame_valid  output  1  frame_data holds an unconsumed frame.
REQ-011 frame_ready  input  1  consumer accepts frame_data when frame_valid=1.
REQ-012 frame_err  output  1  one-cycle pulse: stop bit sampled low.
REQ-013 overrun  output  1  one-cycle pulse: good frame dropped because the output was still occupied.

Function
REQ-014 line_in SHALL pass through a 2-flop synchronizer; all FSM decisions use the synchronized value line_s.
REQ-015 FSM states SHALL be IDLE, START, DATA, STOP and BREAK; a bit timer counts 0..CLKS_PER_BIT-1 and a bit counter counts 0..SIZESREG-1.
REQ-016 IDLE: line_s=0 -> START, timer cleared.
REQ-017 START: after CLKS_PER_BIT/2 cycles, resample line_s; 0 -> DATA with timer cleared; 1 -> IDLE (glitch rejected, no outputs).
REQ-018 DATA: every CLKS_PER_BIT cycles, sample line_s, drive sr_data=sample and sr_enable=1 for exactly that one cycle, then increment the bit counter.
REQ-019 DATA: after the SIZESREG-th strobe -> STOP; exactly SIZESREG strobes per frame, none outside DATA.
REQ-020 STOP: after CLKS_PER_BIT cycles, sample line_s; 1 -> good frame, then IDLE; 0 -> frame_err pulse, frame discarded, then BREAK.
REQ-021 BREAK: remain until line_s=1, then IDLE.
REQ-022 Good frame: frame_data<=sr_q and frame_valid<=1 on the cycle after the stop sample.
REQ-023 frame_data SHALL remain stable while frame_valid=1; frame_valid clears on frame_valid&frame_ready unless a new frame loads in the same cycle.
REQ-024 New good frame with frame_valid=1 and frame_ready=0: overrun pulse; old frame kept, new frame dropped.
REQ-025 New good frame with frame_valid=1 and frame_ready=1 in the same cycle: old frame accepted, new frame loaded, frame_valid stays 1, no overrun.
REQ-026 frame_ready SHALL be ignored while frame_valid=0.

Reset
REQ-027 While RST_N=0 at a rising CLK edge: state=IDLE, counters=0, synchronizer flops=1, sr_enable=0, sr_data=0, frame_data=0, frame_valid=0, frame_err=0, overrun=0.
REQ-028 Reset mid-frame SHALL abandon the frame with no strobe, frame_err or frame_valid afterwards; reception restarts from IDLE on the next start bit.

Structure
REQ-029 Package receptor_pkg SHALL hold the FSM state type and the SIZESREG and CLKS_PER_BIT defaults.
REQ-030 The 2-flop synchronizer SHALL be sub-module sync_2ff (reset value parameterised, here 1); the receptor itself is instantiated beside receptor_ctrl, not inside it.

Verification (SIZESREG=16, CLKS_PER_BIT=4, bench instantiates receptor_ctrl plus receptor)
REQ-031 Frame 0xA5C3 sent MSB-first with good stop bit, frame_ready=1 -> 16 sr_enable strobes 4 cycles apart, frame_valid for 1 cycle, frame_data=0xA5C3.
REQ-032 Low glitch of 1 cycle on idle line -> no sr_enable, no frame_valid, FSM back in IDLE.
REQ-033 Frame 0x1234 with stop bit low, line then held low 20 cycles -> frame_err one pulse, frame_valid stays 0, next frame 0x00FF is received correctly after line returns high.
REQ-034 Frames 0x1111 then 0x2222 with frame_ready=0 -> frame_data=0x1111, overrun one pulse; frame_ready=1 then accepts 0x1111 and frame_valid clears.
REQ-035 frame_ready asserted exactly on the cycle 0x3333 loads while 0x2222 is pending -> no overrun, frame_valid stays 1, frame_data=0x3333.
REQ-036 RST_N=0 for one cycle after the 8th strobe of 0xFFFF -> all outputs 0 next cycle; no further strobes; a following frame 0x0F0F is received correctly.
